// File: rtl/controller_ram_pkg.sv
// Shared types and helpers for the controller RAM arbiter: port-B FSM states,
// data-side access sizes, byte-enable and byte-swap functions.
package controller_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_BRIDGE = 2'd2,
    ST_BRESP  = 2'd3
  } pb_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow store data into every lane so the byte enables pick it up
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/tdp_bram.sv
// True-dual-port 32-bit RAM with per-byte write enables, registered outputs and
// read-old-data behaviour on both ports.
module tdp_bram #(
  parameter int ADDR_WIDTH = 13,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en_a,
  input  logic [3:0]            we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [31:0]           din_a,
  output logic [31:0]           q_a,
  input  logic                  en_b,
  input  logic [3:0]            we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [31:0]           din_b,
  output logic [31:0]           q_b
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Both ports share one process; reads sample the array before this edge's writes
  always_ff @(posedge clk) begin
    if (en_a) begin
      for (int unsigned i = 0; i < 4; i++)
        if (we_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
      q_a <= mem[addr_a];
    end
    if (en_b) begin
      for (int unsigned i = 0; i < 4; i++)
        if (we_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/controller_ram_arbiter.sv
// MPU controller RAM: data bus on port A, fetch and APF bridge arbitrated on port B.
// Optional macro CONTROLLER_RAM_WRITE_LOCK_EN adds cpu_run / bridge_wr_blocked.
module controller_ram_arbiter
  import controller_ram_pkg::*;
#(
  parameter logic [7:0] BRIDGE_BASE = 8'h80,
  parameter int         ADDR_WIDTH  = 13,
  parameter             INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] iBus_cmd_payload_pc,
  input  logic        iBus_cmd_valid,
  output logic        iBus_cmd_ready,
  output logic [31:0] iBus_rsp_payload_inst,
  output logic        iBus_rsp_valid,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_d,
  input  logic        data_we,
  input  logic        dBus_cmd_valid,
  input  logic [1:0]  data_bytesel,
  output logic [31:0] data_q,
  output logic        dBus_rsp_valid,
  input  logic        little_endian,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_rd,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  output logic [31:0] bridge_rd_data,
  output logic        bridge_rd_valid,
  output logic        bridge_busy,
  output logic        bridge_overrun
`ifdef CONTROLLER_RAM_WRITE_LOCK_EN
  ,
  input  logic        cpu_run,
  output logic        bridge_wr_blocked
`endif
);

  localparam int AW = ADDR_WIDTH;

  pb_state_t      state, state_nx;
  logic           active;
  logic           pending, p_wr, clear_pending;
  logic [AW-1:0]  p_addr;
  logic [31:0]    p_data;
  logic           bridge_sel, wr_allowed;

  logic [3:0]     a_we, b_we;
  logic [AW-1:0]  b_addr;
  logic           b_en;
  logic [31:0]    q_a, q_b;
  logic [31:0]    data_hold, inst_hold;

  logic unused_bits;
  assign unused_bits = ^{iBus_cmd_payload_pc[31:AW+2], iBus_cmd_payload_pc[1:0],
                         data_addr[31:AW+2], bridge_addr[23:AW+2], bridge_addr[1:0]};

  assign bridge_sel  = (bridge_addr[31:24] == BRIDGE_BASE) && (bridge_rd || bridge_wr);
  assign bridge_busy = pending;
  assign a_we        = data_we ? byte_enables(data_bytesel, data_addr[1:0]) : '0;

`ifdef CONTROLLER_RAM_WRITE_LOCK_EN
  assign wr_allowed = !cpu_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bridge_wr_blocked <= 1'b0;
    else if (state == ST_BRIDGE && p_wr && cpu_run)
      bridge_wr_blocked <= 1'b1;
  end
`else
  assign wr_allowed = 1'b1;
`endif

  tdp_bram #(
    .ADDR_WIDTH (AW),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .en_a   (dBus_cmd_valid),
    .we_a   (a_we),
    .addr_a (data_addr[AW+1:2]),
    .din_a  (lane_replicate(data_bytesel, data_d)),
    .q_a    (q_a),
    .en_b   (b_en),
    .we_b   (b_we),
    .addr_b (b_addr),
    .din_b  (p_data),
    .q_b    (q_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_nx;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_nx       = state;
    iBus_cmd_ready = 1'b0;
    iBus_rsp_valid = 1'b0;
    b_en           = 1'b0;
    b_we           = '0;
    b_addr         = p_addr;
    clear_pending  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_nx = ST_BRIDGE;
        end else if (active) begin
          iBus_cmd_ready = 1'b1;
          if (iBus_cmd_valid) begin
            b_en     = 1'b1;
            b_addr   = iBus_cmd_payload_pc[AW+1:2];
            state_nx = ST_FETCH;
          end
        end
      end
      // Response for the previous fetch is on q_b now; chain the next only if no bridge waits
      ST_FETCH: begin
        iBus_rsp_valid = 1'b1;
        if (pending) begin
          state_nx = ST_BRIDGE;
        end else begin
          iBus_cmd_ready = 1'b1;
          if (iBus_cmd_valid) begin
            b_en     = 1'b1;
            b_addr   = iBus_cmd_payload_pc[AW+1:2];
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_BRIDGE: begin
        b_en     = 1'b1;
        b_we     = {4{p_wr && wr_allowed}};
        state_nx = ST_BRESP;
      end
      default: begin
        clear_pending = 1'b1;
        state_nx      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending        <= 1'b0;
      p_wr           <= 1'b0;
      p_addr         <= '0;
      p_data         <= '0;
      bridge_overrun <= 1'b0;
    end else begin
      if (clear_pending) pending <= 1'b0;
      if (bridge_sel) begin
        if (pending) begin
          bridge_overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
          p_wr    <= bridge_wr;
          p_addr  <= bridge_addr[AW+1:2];
          p_data  <= little_endian ? bridge_wr_data : byte_swap(bridge_wr_data);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bridge_rd_valid <= 1'b0;
      bridge_rd_data  <= '0;
      inst_hold       <= '0;
      dBus_rsp_valid  <= 1'b0;
      data_hold       <= '0;
    end else begin
      bridge_rd_valid <= 1'b0;
      if (state == ST_BRESP && !p_wr) begin
        bridge_rd_valid <= 1'b1;
        bridge_rd_data  <= little_endian ? q_b : byte_swap(q_b);
      end
      if (state == ST_FETCH) inst_hold <= q_b;
      dBus_rsp_valid <= dBus_cmd_valid && !data_we;
      if (dBus_rsp_valid) data_hold <= q_a;
    end
  end

  // RAM output registers are unreset and shared, so hold copies keep outputs stable
  assign iBus_rsp_payload_inst = (state == ST_FETCH) ? q_b : inst_hold;
  assign data_q                = dBus_rsp_valid ? q_a : data_hold;

endmodule

// File: tb/tb_controller_ram_arbiter.sv
// Self-checking bench for controller_ram_arbiter: data-side vector table plus
// directed bridge, fetch, arbitration, overrun and reset sequences.
module tb_controller_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] iBus_cmd_payload_pc;
  logic        iBus_cmd_valid;
  logic        iBus_cmd_ready;
  logic [31:0] iBus_rsp_payload_inst;
  logic        iBus_rsp_valid;
  logic [31:0] data_addr, data_d, data_q;
  logic        data_we, dBus_cmd_valid, dBus_rsp_valid;
  logic [1:0]  data_bytesel;
  logic        little_endian;
  logic [31:0] bridge_addr, bridge_wr_data, bridge_rd_data;
  logic        bridge_rd, bridge_wr, bridge_rd_valid, bridge_busy, bridge_overrun;
`ifdef CONTROLLER_RAM_WRITE_LOCK_EN
  logic        cpu_run, bridge_wr_blocked;
`endif

  always #5 clk = ~clk;

  controller_ram_arbiter #(
    .BRIDGE_BASE (8'h80),
    .ADDR_WIDTH  (13),
    .INIT_FILE   ("")
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .iBus_cmd_payload_pc   (iBus_cmd_payload_pc),
    .iBus_cmd_valid        (iBus_cmd_valid),
    .iBus_cmd_ready        (iBus_cmd_ready),
    .iBus_rsp_payload_inst (iBus_rsp_payload_inst),
    .iBus_rsp_valid        (iBus_rsp_valid),
    .data_addr             (data_addr),
    .data_d                (data_d),
    .data_we               (data_we),
    .dBus_cmd_valid        (dBus_cmd_valid),
    .data_bytesel          (data_bytesel),
    .data_q                (data_q),
    .dBus_rsp_valid        (dBus_rsp_valid),
    .little_endian         (little_endian),
    .bridge_addr           (bridge_addr),
    .bridge_rd             (bridge_rd),
    .bridge_wr             (bridge_wr),
    .bridge_wr_data        (bridge_wr_data),
    .bridge_rd_data        (bridge_rd_data),
    .bridge_rd_valid       (bridge_rd_valid),
    .bridge_busy           (bridge_busy),
    .bridge_overrun        (bridge_overrun)
`ifdef CONTROLLER_RAM_WRITE_LOCK_EN
    ,
    .cpu_run               (cpu_run),
    .bridge_wr_blocked     (bridge_wr_blocked)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic d_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
    dBus_cmd_valid = 1'b1;
    data_we        = we;
    data_bytesel   = size;
    data_addr      = addr;
    data_d         = wdata;
    tick;
    dBus_cmd_valid = 1'b0;
    data_we        = 1'b0;
  endtask

  task automatic d_write(input logic [31:0] addr, input logic [31:0] wdata);
    d_access(1'b1, 2'd2, addr, wdata);
  endtask

  task automatic d_read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    d_access(1'b0, 2'd2, addr, 32'h0);
    chk({name, "_valid"}, {31'b0, dBus_rsp_valid}, 32'd1);
    chk(name, data_q, exp);
  endtask

  task automatic bridge_pulse(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata);
    bridge_rd      = rd;
    bridge_wr      = wr;
    bridge_addr    = addr;
    bridge_wr_data = wdata;
    tick;
    bridge_rd = 1'b0;
    bridge_wr = 1'b0;
  endtask

  task automatic bridge_wait_idle(input string name);
    int n;
    n = 0;
    while (bridge_busy && n < 12) begin
      tick;
      n++;
    end
    chk({name, "_busy_drop"}, {31'b0, bridge_busy}, 32'd0);
  endtask

  task automatic bridge_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    bridge_pulse(1'b1, 1'b0, addr, 32'h0);
    lat = 1;
    while (!bridge_rd_valid && lat < 12) begin
      tick;
      lat++;
    end
    data = bridge_rd_data;
  endtask

  task automatic run_fetch(input logic [31:0] pc0, input int n, input int inj,
                           input logic [31:0] baddr, output int got, output int first,
                           output int last, output int viol, output int brv,
                           output int br_lat, output logic [31:0] brdata);
    logic [31:0] expq[$];
    logic [31:0] pc, e;
    logic        acc;
    int          issued, cyc;
    got = 0; first = -1; last = -1; viol = 0; brv = 0; br_lat = -1; brdata = '0;
    issued = 0; cyc = 0; pc = pc0;
    iBus_cmd_valid = 1'b1;
    while (got < n && cyc < 80) begin
      iBus_cmd_payload_pc = pc;
      bridge_rd = (cyc == inj);
      if (cyc == inj) bridge_addr = baddr;
      acc = iBus_cmd_valid && iBus_cmd_ready;
      if (acc) expq.push_back(32'h1000_0000 + (pc >> 2));
      if (bridge_busy && iBus_cmd_ready) viol++;
      tick;
      cyc++;
      if (acc) begin
        issued++;
        pc += 4;
      end
      iBus_cmd_valid = (issued < n);
      if (iBus_rsp_valid) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL fetch_spurious: actual=rsp_valid required=no_response cycle=%0d", cyc);
        end else begin
          e = expq.pop_front();
          chk("fetch_inst", iBus_rsp_payload_inst, e);
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bridge_rd_valid) begin
        brv++;
        brdata = bridge_rd_data;
        br_lat = cyc - inj;
      end
    end
    iBus_cmd_valid = 1'b0;
    bridge_rd      = 1'b0;
    repeat (8) begin
      tick;
      cyc++;
      if (iBus_rsp_valid) got++;
      if (bridge_rd_valid) begin
        brv++;
        brdata = bridge_rd_data;
        br_lat = cyc - inj;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } dvec_t;

  dvec_t dv [16];

  initial begin
    logic [31:0] last_q, rdat;
    int          lat, got, first, last, viol, brv, br_lat, cnt;
    logic [31:0] brdata;

    reset_n = 1'b0;
    iBus_cmd_payload_pc = '0; iBus_cmd_valid = 1'b0;
    data_addr = '0; data_d = '0; data_we = 1'b0; dBus_cmd_valid = 1'b0; data_bytesel = '0;
    little_endian = 1'b0;
    bridge_addr = '0; bridge_rd = 1'b0; bridge_wr = 1'b0; bridge_wr_data = '0;
`ifdef CONTROLLER_RAM_WRITE_LOCK_EN
    cpu_run = 1'b0;
`endif

    dv[0]  = '{1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000, 32'h0};
    dv[1]  = '{1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AB, 32'h0};
    dv[2]  = '{1'b1, 2'd1, 32'h0000_0000, 32'h0000_CDEF, 32'h0};
    dv[3]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'hAB00_CDEF};
    dv[4]  = '{1'b1, 2'd2, 32'h0000_0010, 32'h1234_5678, 32'h0};
    dv[5]  = '{1'b1, 2'd0, 32'h0000_0011, 32'h0000_0099, 32'h0};
    dv[6]  = '{1'b1, 2'd1, 32'h0000_0012, 32'h0000_BEEF, 32'h0};
    dv[7]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         32'hBEEF_9978};
    dv[8]  = '{1'b1, 2'd2, 32'h0000_8000, 32'hCAFE_F00D, 32'h0};
    dv[9]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0,         32'hCAFE_F00D};
    dv[10] = '{1'b1, 2'd1, 32'h0000_0001, 32'h0000_1111, 32'h0};
    dv[11] = '{1'b0, 2'd0, 32'h0000_8002, 32'h0,         32'hCAFE_1111};
    dv[12] = '{1'b1, 2'd3, 32'h0000_0014, 32'hA5A5_5A5A, 32'h0};
    dv[13] = '{1'b0, 2'd2, 32'h0000_0014, 32'h0,         32'hA5A5_5A5A};
    dv[14] = '{1'b1, 2'd0, 32'h0000_0016, 32'h0000_003C, 32'h0};
    dv[15] = '{1'b0, 2'd1, 32'h0000_0014, 32'h0,         32'hA53C_5A5A};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'b0, iBus_cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, iBus_rsp_valid}, 32'd0);
    chk("rst_inst", iBus_rsp_payload_inst, 32'd0);
    chk("rst_data_q", data_q, 32'd0);
    chk("rst_dbus_valid", {31'b0, dBus_rsp_valid}, 32'd0);
    chk("rst_br_data", bridge_rd_data, 32'd0);
    chk("rst_br_valid", {31'b0, bridge_rd_valid}, 32'd0);
    chk("rst_busy", {31'b0, bridge_busy}, 32'd0);
    chk("rst_overrun", {31'b0, bridge_overrun}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    chk("idle_cmd_ready", {31'b0, iBus_cmd_ready}, 32'd1);

    // Data-side vector table
    last_q = 32'h0;
    for (int i = 0; i < 16; i++) begin
      d_access(dv[i].we, dv[i].size, dv[i].addr, dv[i].wdata);
      if (dv[i].we) begin
        chk($sformatf("dvec%0d_valid", i), {31'b0, dBus_rsp_valid}, 32'd0);
        chk($sformatf("dvec%0d_hold", i), data_q, last_q);
      end else begin
        chk($sformatf("dvec%0d_valid", i), {31'b0, dBus_rsp_valid}, 32'd1);
        chk($sformatf("dvec%0d_q", i), data_q, dv[i].exp);
        last_q = dv[i].exp;
      end
    end

    // Prefill fetch region and scratch words
    for (int i = 0; i < 8; i++) d_write(32'h80 + 4*i, 32'h1000_0020 + i);
    d_write(32'h0C, 32'h3333_3333);
    d_write(32'hC4, 32'h5555_5555);

    // Upload with byte reversal, then readback
    little_endian = 1'b0;
    bridge_pulse(1'b0, 1'b1, 32'h8000_0004, 32'h1122_3344);
    chk("upload_busy", {31'b0, bridge_busy}, 32'd1);
    bridge_wait_idle("upload");
    d_read_chk("upload_word1", 32'h4, 32'h4433_2211);
    bridge_read(32'h8000_0004, rdat, lat);
    chk("readback_valid", {31'b0, bridge_rd_valid}, 32'd1);
    chk("readback_data", rdat, 32'h1122_3344);
    chk("readback_lat_le5", {31'b0, (lat <= 5)}, 32'd1);
    tick;
    chk("readback_pulse_end", {31'b0, bridge_rd_valid}, 32'd0);
    chk("readback_hold", bridge_rd_data, 32'h1122_3344);

    // Straight-through byte order
    little_endian = 1'b1;
    bridge_pulse(1'b0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF);
    bridge_wait_idle("le_write");
    d_read_chk("le_word2", 32'h8, 32'hDEAD_BEEF);
    bridge_read(32'h8000_0008, rdat, lat);
    chk("le_readback", rdat, 32'hDEAD_BEEF);

    // Wrong base is ignored
    bridge_pulse(1'b0, 1'b1, 32'h7F00_000C, 32'h0);
    chk("nobase_busy", {31'b0, bridge_busy}, 32'd0);
    d_read_chk("nobase_word3", 32'hC, 32'h3333_3333);

    // rd+wr together acts as a write
    cnt = 0;
    bridge_pulse(1'b1, 1'b1, 32'h8000_00C8, 32'h0000_0077);
    repeat (6) begin
      if (bridge_rd_valid) cnt++;
      tick;
    end
    chk("rdwr_no_rdvalid", cnt, 32'd0);
    d_read_chk("rdwr_word", 32'hC8, 32'h0000_0077);

    // Fetch stream of three
    run_fetch(32'h80, 3, -1, 32'h0, got, first, last, viol, brv, br_lat, brdata);
    chk("stream_count", got, 32'd3);
    chk("stream_back_to_back", last - first, 32'd2);

    // Data read and fetch in the same cycle
    chk("simul_ready", {31'b0, iBus_cmd_ready}, 32'd1);
    iBus_cmd_valid = 1'b1;
    iBus_cmd_payload_pc = 32'h84;
    d_access(1'b0, 2'd2, 32'h0, 32'h0);
    iBus_cmd_valid = 1'b0;
    chk("simul_dvalid", {31'b0, dBus_rsp_valid}, 32'd1);
    chk("simul_dq", data_q, 32'hCAFE_1111);
    chk("simul_ivalid", {31'b0, iBus_rsp_valid}, 32'd1);
    chk("simul_inst", iBus_rsp_payload_inst, 32'h1000_0021);
    tick;

    // Bridge read injected into a fetch stream
    little_endian = 1'b0;
    run_fetch(32'h80, 6, 2, 32'h8000_0004, got, first, last, viol, brv, br_lat, brdata);
    chk("arb_fetch_count", got, 32'd6);
    chk("arb_ready_low_when_busy", viol, 32'd0);
    chk("arb_rdvalid_pulses", brv, 32'd1);
    chk("arb_rd_data", brdata, 32'h1122_3344);
    chk("arb_lat_le5", {31'b0, (br_lat >= 1 && br_lat <= 5)}, 32'd1);

    // Overrun: second write one cycle later is dropped
    little_endian = 1'b1;
    chk("overrun_before", {31'b0, bridge_overrun}, 32'd0);
    bridge_rd = 1'b0;
    bridge_wr = 1'b1;
    bridge_addr = 32'h8000_00C0;
    bridge_wr_data = 32'hAAAA_0001;
    tick;
    chk("overrun_busy", {31'b0, bridge_busy}, 32'd1);
    bridge_addr = 32'h8000_00C4;
    bridge_wr_data = 32'hBBBB_0002;
    tick;
    bridge_wr = 1'b0;
    bridge_wait_idle("overrun");
    chk("overrun_set", {31'b0, bridge_overrun}, 32'd1);
    d_read_chk("overrun_first", 32'hC0, 32'hAAAA_0001);
    d_read_chk("overrun_second", 32'hC4, 32'h5555_5555);
    tick;
    chk("overrun_sticky", {31'b0, bridge_overrun}, 32'd1);

`ifdef CONTROLLER_RAM_WRITE_LOCK_EN
    // Write lock while the CPU runs
    cpu_run = 1'b1;
    bridge_pulse(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    bridge_wait_idle("lock");
    d_read_chk("lock_unchanged", 32'h10, 32'hBEEF_9978);
    chk("lock_blocked", {31'b0, bridge_wr_blocked}, 32'd1);
    cpu_run = 1'b0;
    bridge_pulse(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    bridge_wait_idle("unlock");
    d_read_chk("unlock_written", 32'h10, 32'hDEAD_BEEF);
`endif

    // Same-address collision: fetch sees old data
    dBus_cmd_valid = 1'b1;
    data_we = 1'b1;
    data_bytesel = 2'd2;
    data_addr = 32'h80;
    data_d = 32'hFFFF_0000;
    iBus_cmd_valid = 1'b1;
    iBus_cmd_payload_pc = 32'h80;
    tick;
    dBus_cmd_valid = 1'b0;
    data_we = 1'b0;
    iBus_cmd_valid = 1'b0;
    chk("coll_old_inst", iBus_rsp_payload_inst, 32'h1000_0020);
    tick;
    iBus_cmd_valid = 1'b1;
    tick;
    iBus_cmd_valid = 1'b0;
    chk("coll_new_inst", iBus_rsp_payload_inst, 32'hFFFF_0000);
    tick;

    // Reset in the middle of a bridge read
    little_endian = 1'b0;
    bridge_pulse(1'b1, 1'b0, 32'h8000_0004, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, bridge_busy}, 32'd0);
    chk("midrst_overrun", {31'b0, bridge_overrun}, 32'd0);
    chk("midrst_br_data", bridge_rd_data, 32'd0);
    chk("midrst_data_q", data_q, 32'd0);
    chk("midrst_ready", {31'b0, iBus_cmd_ready}, 32'd0);
`ifdef CONTROLLER_RAM_WRITE_LOCK_EN
    chk("midrst_blocked", {31'b0, bridge_wr_blocked}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick;
      if (bridge_rd_valid) cnt++;
    end
    chk("midrst_no_rdvalid", cnt, 32'd0);
    chk("midrst_idle_ready", {31'b0, iBus_cmd_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/controller_ram_arbiter.md
Name: controller_ram_arbiter

Overview:
- Parametrised successor to the MPU controller memory block.
- Holds one true-dual-port RAM shared by three masters:
  - MPU data bus, on port A.
  - MPU instruction fetch, on port B.
  - APF bridge upload/readback, also on port B.
- A port-B arbiter FSM gives bridge accesses priority over fetch with a clean ready/valid handshake. Bridge readback is a registered valid pulse.
- Sits between the VexRiscv-style MPU and the bridge CDC. All bridge inputs arrive already synchronised to clk.

Parameters:
- BRIDGE_BASE, 8'h80, value of bridge_addr[31:24] that selects this block.
- ADDR_WIDTH, 13, word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words.
- INIT_FILE, "", optional RAM init file passed to the RAM sub-module.

Ports:
- clk  in  1  core clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- iBus_cmd_payload_pc  in  32  fetch byte address; bits [ADDR_WIDTH+1:2] are used.
- iBus_cmd_valid  in  1  fetch request.
- iBus_cmd_ready  out  1  fetch accepted when valid&&ready.
- iBus_rsp_payload_inst  out  32  fetched instruction.
- iBus_rsp_valid  out  1  one-cycle pulse, instruction valid.
- data_addr  in  32  data byte address.
- data_d  in  32  write data.
- data_we  in  1  write strobe (qualified by dBus_cmd_valid).
- dBus_cmd_valid  in  1  data access request.
- data_bytesel  in  2  access size: 0 = byte, 1 = half, 2/3 = word.
- data_q  out  32  read data.
- dBus_rsp_valid  out  1  read data valid pulse.
- little_endian  in  1  0 = byte-reverse bridge data in both directions.
- bridge_addr  in  32  bridge byte address.
- bridge_rd  in  1  read pulse.
- bridge_wr  in  1  write pulse.
- bridge_wr_data  in  32  write data.
- bridge_rd_data  out  32  registered read data, held until the next read.
- bridge_rd_valid  out  1  one-cycle pulse.
- bridge_busy  out  1  a bridge request is pending or executing.
- bridge_overrun  out  1  sticky; a request was dropped while busy.

Behaviour:
- Reset: every output is 0; the FSM goes to IDLE; the pending request is cleared. Reset asserted mid-operation aborts the operation. Any write already issued to the RAM completes; nothing else does.
- Bridge select: a request is selected when bridge_addr[31:24]==BRIDGE_BASE and (bridge_rd or bridge_wr).
  - bridge_rd and bridge_wr together are treated as a write.
  - A selected request while bridge_busy=0 latches address, data and kind. bridge_busy rises the next cycle.
  - A selected request while bridge_busy=1 is dropped and sets bridge_overrun. Only reset clears it.
- Port A (data):
  - Always ready. Read latency is 1 cycle: dBus_rsp_valid pulses the cycle after dBus_cmd_valid&&!data_we.
  - data_q holds its value until the next read.
  - Byte enables for size 0: 0001/0010/0100/1000 by addr[1:0].
  - Byte enables for size 1: 0011 for addr[1]=0, 1100 for addr[1]=1; addr[0] is ignored.
  - Byte enables for size 2/3: 1111.
  - Address bits above ADDR_WIDTH+1 are ignored, so accesses wrap modulo the RAM size.
- Port B FSM:
  - IDLE:
    - With a pending request: go to BRIDGE; iBus_cmd_ready=0.
    - Otherwise: iBus_cmd_ready=1. An accepted fetch issues a port-B read, then the next state is FETCH.
  - FETCH:
    - iBus_rsp_valid=1 for exactly one cycle, and iBus_rsp_payload_inst updates.
    - A back-to-back fetch may be accepted in the same cycle only if nothing is pending. Otherwise go to BRIDGE.
  - BRIDGE: issue the port-B read or write; go to BRESP.
  - BRESP:
    - For a read: latch bridge_rd_data and pulse bridge_rd_valid.
    - Clear pending; bridge_busy falls; go to IDLE.
- Fetch throughput is 1 per cycle when the bridge is idle. Bridge latency from the request pulse to bridge_rd_valid is at most 5 cycles.
- A fetch in flight always delivers its response before any bridge access starts. A fetch is never dropped or duplicated.
- When little_endian=0, bridge write data and bridge read data are byte-reversed ({[7:0],[15:8],[23:16],[31:24]}). When little_endian=1, they pass straight through.
- A same-address collision between port A and port B is read-old-data. The data side is never stalled.

Optional Feature:
- Macro CONTROLLER_RAM_WRITE_LOCK_EN adds input cpu_run (1 bit).
- Defined: bridge writes are executed only while cpu_run=0.
  - A write while cpu_run=1 still completes the FSM handshake, but does not write the RAM.
  - It sets sticky output bridge_wr_blocked.
  - Bridge reads are unaffected.
- Undefined: no cpu_run or bridge_wr_blocked ports; bridge writes always execute.

Decomposition:
- Package controller_ram_pkg:
  - FSM state encoding IDLE/FETCH/BRIDGE/BRESP.
  - Size codes BYTE/HALF/WORD.
  - Byte-enable function.
  - Byte-swap function.
- Sub-module tdp_bram:
  - Parametrised true-dual-port RAM: ADDR_WIDTH, INIT_FILE, 4-bit byte enables on both ports, registered outputs, read-old-data.

Test Plan:
- Upload: little_endian=0, bridge_wr addr 0x8000_0004 data 0x1122_3344 -> word 1 = 0x4433_2211. A bridge_rd of the same address returns bridge_rd_data=0x1122_3344 with one bridge_rd_valid pulse, ≤5 cycles after the request.
- Fetch stream: iBus_cmd_valid held high, pc 0,4,8 -> three consecutive iBus_rsp_valid pulses, instructions = words 0,1,2.
- Arbitration: bridge_rd arrives during a fetch stream -> the in-flight fetch responds, iBus_cmd_ready=0 for the bridge window, the fetch stream resumes, and no fetch is lost.
- Overrun: two bridge_wr pulses 1 cycle apart -> only the first write lands, bridge_overrun=1.
- Data side: store byte 0xAB at 0x0003, then store half 0xCDEF at 0x0000 (pre-fill word 0 = 0). Reading word 0 gives data_q=0xAB00_CDEF. A simultaneous fetch of another address is not stalled.
- Write lock (macro defined, cpu_run=1): bridge_wr 0xDEAD_BEEF -> RAM unchanged and bridge_wr_blocked=1. With cpu_run=0 the write lands.
